hack_boot_ctrl: RTL and testbench

Boot sequencer for the Hack CPU. It holds the CPU in reset and receives a program image over an 8-bit valid/ready byte stream. Each received word is written into instruction ROM, the image checksum is verified, and the CPU is then released from reset. It sits between the host link (UART receiver) and the instruction ROM write port and CPU reset input.

---
 rtl/hack_boot_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hack_boot_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_ctrl.sv
// Boot sequencer for the Hack CPU.
// Holds the CPU in reset while a program image arrives as a byte stream:
//   N_hi, N_lo, N x (hi, lo), CSUM
// Each word is written to instruction ROM. CSUM must equal the 8-bit
// wrap-around sum of every preceding image byte. After a good checksum the
// CPU stays in reset for RST_HOLD more cycles and is then released.
// boot_req restarts the whole sequence from any state.
module hack_boot_ctrl #(
    parameter int ADDR_W   = 15,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              rom_we,
    output logic              cpu_reset,
    output logic              running,
    output logic              err,
    output logic [ADDR_W:0]   words
);

    typedef enum logic [2:0] {
        HDR_HI  = 3'd0,
        HDR_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CSUM    = 3'd4,
        HOLD    = 3'd5,
        RUN     = 3'd6,
        ERROR   = 3'd7
    } state_t;

    // ROM capacity, held at 17 bits so that N (16 bits) compares without truncation.
    localparam logic [16:0] ROM_WORDS = 17'd1 << ADDR_W;
    localparam logic [7:0]  HOLD_INIT = 8'(RST_HOLD);

    state_t      state_r;
    state_t      state_n;
    logic [15:0] len_r;
    logic [7:0]  acc_r;
    logic [7:0]  hi_r;
    logic [7:0]  cnt_r;
    logic        accept_s;
    logic [16:0] hdr_len_s;
    logic [16:0] words_inc_s;

    // 8-bit wrap-around checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign accept_s    = rx_valid && rx_ready;
    assign hdr_len_s   = {1'b0, len_r[15:8], rx_data};
    assign words_inc_s = 17'(words) + 17'd1;

    // Byte-accepting states take a byte unless a restart is being requested.
    always_comb begin
        rx_ready = 1'b0;
        case (state_r)
            HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM: rx_ready = !boot_req;
            default:                                rx_ready = 1'b0;
        endcase
    end

    // Next-state logic; boot_req overrides everything.
    always_comb begin
        state_n = state_r;
        if (boot_req) begin
            state_n = HDR_HI;
        end else begin
            case (state_r)
                HDR_HI: begin
                    if (accept_s) state_n = HDR_LO;
                    else          state_n = state_r;
                end
                HDR_LO: begin
                    if (!accept_s)                  state_n = state_r;
                    else if (hdr_len_s > ROM_WORDS) state_n = ERROR;
                    else if (hdr_len_s == 17'd0)    state_n = CSUM;
                    else                            state_n = DATA_HI;
                end
                DATA_HI: begin
                    if (accept_s) state_n = DATA_LO;
                    else          state_n = state_r;
                end
                DATA_LO: begin
                    if (!accept_s)                         state_n = state_r;
                    else if (words_inc_s == {1'b0, len_r}) state_n = CSUM;
                    else                                   state_n = DATA_HI;
                end
                CSUM: begin
                    if (!accept_s)             state_n = state_r;
                    else if (rx_data == acc_r) state_n = HOLD;
                    else                       state_n = ERROR;
                end
                HOLD: begin
                    if (cnt_r <= 8'd1) state_n = RUN;
                    else               state_n = HOLD;
                end
                RUN:     state_n = RUN;
                ERROR:   state_n = ERROR;
                default: state_n = HDR_HI;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= HDR_HI;
        else       state_r <= state_n;
    end

    // Datapath: header/length capture, checksum, ROM write strobe, hold counter, status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r     <= 16'd0;
            acc_r     <= 8'd0;
            hi_r      <= 8'd0;
            cnt_r     <= 8'd0;
            words     <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= 16'd0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            err       <= 1'b0;
        end else begin
            rom_we    <= 1'b0;
            cpu_reset <= (state_n != RUN);
            running   <= (state_n == RUN);
            err       <= (state_n == ERROR);
            if (boot_req) begin
                len_r <= 16'd0;
                acc_r <= 8'd0;
                hi_r  <= 8'd0;
                cnt_r <= 8'd0;
                words <= '0;
            end else begin
                // The checksum byte itself is not part of the sum.
                if (accept_s && (state_r != CSUM)) acc_r <= csum_add(acc_r, rx_data);
                case (state_r)
                    HDR_HI:  if (accept_s) len_r[15:8] <= rx_data;
                    HDR_LO:  if (accept_s) len_r[7:0]  <= rx_data;
                    DATA_HI: if (accept_s) hi_r        <= rx_data;
                    DATA_LO: begin
                        if (accept_s) begin
                            rom_we    <= 1'b1;
                            rom_addr  <= words[ADDR_W-1:0];
                            rom_wdata <= {hi_r, rx_data};
                            words     <= words + {{ADDR_W{1'b0}}, 1'b1};
                        end
                    end
                    CSUM:    if (accept_s) cnt_r <= HOLD_INIT;
                    HOLD:    cnt_r <= cnt_r - 8'd1;
                    default: cnt_r <= cnt_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Self-checking bench for hack_boot_ctrl with a small ROM (ADDR_W=4, 16 words)
// so that full-ROM and oversize-length images are cheap to exercise.
module tb_hack_boot_ctrl;

    localparam int AW   = 4;
    localparam int HOLD = 4;
    localparam int CAP  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          boot_req = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          rom_we;
    logic          cpu_reset;
    logic          running;
    logic          err;
    logic [AW:0]   words;

    int errors = 0;
    int checks = 0;

    logic [19:0] obs_q[$];
    logic [15:0] img[0:CAP];

    typedef struct {
        int n;
        bit corrupt;
        int gap;
        bit exp_err;
        int exp_words;
    } vec_t;
    vec_t vecs[8];

    hack_boot_ctrl #(.ADDR_W(AW), .RST_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .boot_req(boot_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rom_addr(rom_addr), .rom_wdata(rom_wdata), .rom_we(rom_we),
        .cpu_reset(cpu_reset), .running(running), .err(err), .words(words)
    );

    always #5 clk = ~clk;

    // Record every ROM write strobe (one entry per high cycle).
    always @(negedge clk) begin
        if (rom_we) obs_q.push_back({rom_addr, rom_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one byte after 'gap' idle cycles; returns right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        while (!done) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            #1;
            if (rx_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                t++;
                if (t > 50) begin
                    check("rx_ready_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic restart();
        @(negedge clk);
        rx_valid = 1'b0;
        boot_req = 1'b1;
        #1;
        check("bootreq_ready_low", rx_ready, 0);
        @(negedge clk);
        boot_req = 1'b0;
        #1;
        check("bootreq_cpu_reset", cpu_reset, 1);
        check("bootreq_running", running, 0);
        check("bootreq_err", err, 0);
        check("bootreq_words", words, 0);
        check("bootreq_ready", rx_ready, 1);
    endtask

    // Send a whole image and compare against the image's own arithmetic.
    task automatic run_image(input int n, input bit corrupt, input int gap,
                             input bit exp_err, input int exp_words);
        logic [15:0] nn;
        logic [7:0]  sum;
        nn = n[15:0];
        obs_q.delete();
        sum = nn[15:8] + nn[7:0];
        if (n <= CAP) begin
            for (int i = 0; i < n; i++) begin
                if (n == 2) img[i] = (i == 0) ? 16'h3039 : 16'hEC10;
                else        img[i] = 16'($urandom);
                sum = sum + img[i][15:8] + img[i][7:0];
            end
        end
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        if (n > CAP) begin
            @(negedge clk);
            rx_valid = 1'b0;
            #1;
            check("len_err_next_cycle", err, 1);
            check("len_err_ready", rx_ready, 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                send_byte(img[i][15:8], gap);
                send_byte(img[i][7:0], gap);
            end
            send_byte(corrupt ? sum + 8'd1 : sum, gap);
            @(negedge clk);
            rx_valid = 1'b0;
            #1;
            if (!exp_err) begin
                for (int k = 0; k < HOLD; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        #1;
                    end
                    check("hold_cpu_reset", cpu_reset, 1);
                    check("hold_running", running, 0);
                end
                @(negedge clk);
                #1;
                check("run_cpu_reset", cpu_reset, 0);
                check("run_running", running, 1);
            end
        end
        repeat (2) @(negedge clk);
        #1;
        check("write_count", obs_q.size(), (n > CAP) ? 0 : n);
        for (int i = 0; i < obs_q.size() && i < n && n <= CAP; i++) begin
            check("write_addr", obs_q[i][19:16], i);
            check("write_data", obs_q[i][15:0], img[i]);
        end
        check("err", err, exp_err);
        check("words", words, exp_words);
        check("ready_after", rx_ready, 0);
        check("cpu_reset_final", cpu_reset, exp_err ? 1 : 0);
        check("running_final", running, exp_err ? 0 : 1);
    endtask

    initial begin
        vecs[0] = '{2,   1'b0, 0, 1'b0, 2};   // basic two-word image
        vecs[1] = '{2,   1'b1, 0, 1'b1, 2};   // bad checksum
        vecs[2] = '{0,   1'b0, 0, 1'b0, 0};   // empty image
        vecs[3] = '{17,  1'b0, 0, 1'b1, 0};   // one word too many
        vecs[4] = '{2,   1'b0, 2, 1'b0, 2};   // one byte every 3 cycles
        vecs[5] = '{16,  1'b0, 0, 1'b0, 16};  // exactly full ROM
        vecs[6] = '{256, 1'b0, 1, 1'b1, 0};   // oversize via the high byte
        vecs[7] = '{1,   1'b1, 1, 1'b1, 1};

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_running", running, 0);
        check("rst_err", err, 0);
        check("rst_rom_we", rom_we, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_wdata", rom_wdata, 0);
        check("rst_words", words, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", rx_ready, 1);

        // Table-driven images.
        for (int v = 0; v < 8; v++) begin
            run_image(vecs[v].n, vecs[v].corrupt, vecs[v].gap, vecs[v].exp_err, vecs[v].exp_words);
            restart();
        end

        // Abort mid-load: boot_req together with the hi byte of word 1.
        obs_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h30, 0);
        send_byte(8'h39, 0);
        @(negedge clk);
        boot_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hEC;
        #1;
        check("abort_ready_low", rx_ready, 0);
        @(negedge clk);
        boot_req = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("abort_words", words, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_ready", rx_ready, 1);
        check("abort_writes", obs_q.size(), 1);
        run_image(2, 1'b0, 0, 1'b0, 2);

        // Async reset while running takes effect without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_cpu_reset", cpu_reset, 1);
        check("async_running", running, 0);
        check("async_words", words, 0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized images against the arithmetic model.
        for (int r = 0; r < 8; r++) begin
            int n;
            bit c;
            bit e;
            n = $urandom_range(0, CAP + 2);
            c = ($urandom_range(0, 3) == 0);
            e = (n > CAP) || c;
            run_image(n, c, $urandom_range(0, 2), e, (n > CAP) ? 0 : n);
            restart();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
